// File: rtl/uart_rx_fc.sv
// uart_rx_fc -- flow-controlled 8N1 UART receiver.
//
// Recovers 8N1 frames from an asynchronous rx line, stores the received bytes
// in a small first-word-fall-through FIFO drained through a valid/ready port,
// and drives an active-low rts so the remote transmitter can be throttled
// before the FIFO overflows.
//
// Parameters:
//   CLK_DIV        clk cycles per serial bit (>= 8)
//   FIFO_ADDR_BITS FIFO depth is 2**FIFO_ADDR_BITS entries
//   RTS_MARGIN     free entries remaining when rts goes high (1 .. depth-1)
//
// Ports:
//   clk        single clock, rising edge
//   resetn     synchronous active-low reset
//   rx         asynchronous serial input, idles high
//   rts        registered active-low ready-to-send (1 = stop sending)
//   rd_data    byte at the FIFO head (valid only while rd_valid)
//   rd_valid   FIFO not empty
//   rd_ready   pops the head when rd_valid & rd_ready
//   level      FIFO occupancy
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a good byte was dropped because the FIFO was full
//   clr_err    single-cycle pulse clearing both sticky flags

module uart_rx_fc #(
    parameter int CLK_DIV        = 104,
    parameter int FIFO_ADDR_BITS = 4,
    parameter int RTS_MARGIN     = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      rx,
    output logic                      rts,
    output logic [7:0]                rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [FIFO_ADDR_BITS:0]   level,
    output logic                      frame_err,
    output logic                      overrun,
    input  logic                      clr_err
);

    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int CW    = $clog2(CLK_DIV);
    localparam int LW    = FIFO_ADDR_BITS + 1;

    localparam logic [CW-1:0] CNT_HALF   = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] RTS_LEVEL  = LW'(DEPTH - RTS_MARGIN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;

    logic sample_bit;
    logic stop_hit;
    logic push_req;
    logic ferr_set;
    logic cnt_clr;

    logic [7:0]                mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr;
    logic [LW-1:0]             level_next;
    logic                      full;
    logic                      pop;
    logic                      push;
    logic                      ovr_set;

    // Two-flop synchronizer; both flops reset to the idle level so a reset
    // never manufactures a start bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ---- frame FSM: state register ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- frame FSM: next-state logic ----
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rx_s) state_next = START;
            // A start bit that is high again at mid-bit is treated as a glitch.
            START: if (cnt == CNT_HALF) state_next = rx_s ? IDLE : DATA;
            DATA:  if (cnt == CNT_LAST && idx == 3'd7) state_next = STOP;
            STOP:  if (cnt == CNT_LAST) state_next = rx_s ? IDLE : BREAK;
            BREAK: if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---- frame FSM: outputs ----
    always_comb begin
        sample_bit = (state == DATA) && (cnt == CNT_LAST);
        stop_hit   = (state == STOP) && (cnt == CNT_LAST);
        push_req   = stop_hit && rx_s;
        ferr_set   = stop_hit && !rx_s;
        // The counter restarts on every state change and after every data
        // sample, so each phase measures time from its own entry point.
        cnt_clr    = (state != state_next) || sample_bit ||
                     (state == IDLE) || (state == BREAK);
    end

    // Bit timing counter and bit index.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (state == START) begin
                idx <= '0;
            end else if (sample_bit) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Receive shift register, LSB first.
    always_ff @(posedge clk) begin
        if (sample_bit) begin
            shreg[idx] <= rx_s;
        end
    end

    // ---- FIFO control ----
    always_comb begin
        rd_valid = (level != '0);
        full     = (level == FULL_LEVEL);
        pop      = rd_valid && rd_ready;
        // When full, a simultaneous pop frees the slot being written.
        push     = push_req && (!full || pop);
        ovr_set  = push_req && full && !pop;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rts       <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_ADDR_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_ADDR_BITS'(1);
            level     <= level_next;
            rts       <= (level_next >= RTS_LEVEL);
            // A new error in the same cycle as clr_err leaves the flag set.
            frame_err <= ferr_set || (frame_err && !clr_err);
            overrun   <= ovr_set  || (overrun   && !clr_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_fc.sv
// tb_uart_rx_fc -- scoreboard bench for uart_rx_fc (CLK_DIV=16, depth 4,
// RTS_MARGIN=1). Expected bytes are queued as frames are sent; a monitor
// pops and compares on every rd_valid & rd_ready handshake.

`timescale 1ns/1ps

module tb_uart_rx_fc;

    localparam int CLK_DIV = 16;

    logic       clk;
    logic       resetn;
    logic       rx;
    logic       rts;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [2:0] level;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    uart_rx_fc #(
        .CLK_DIV(CLK_DIV),
        .FIFO_ADDR_BITS(2),
        .RTS_MARGIN(1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .rx(rx),
        .rts(rts),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .level(level),
        .frame_err(frame_err),
        .overrun(overrun),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every popped byte against the scoreboard.
    always @(negedge clk) begin
        if (resetn && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got %0h, expected no data", rd_data);
            end else begin
                check("pop_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CLK_DIV) tick();
    endtask

    // Sends one 8N1 frame starting just after a clock edge E0. The stop-bit
    // sample lands on E156; with pop_at_push, rd_ready is high for exactly
    // the cycle ending on that edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_push);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        rx = stop;
        for (int c = 0; c < CLK_DIV; c++) begin
            if (pop_at_push) rd_ready = (c == 11);
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) tick();
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        rx       = 1'b1;
        rd_ready = 1'b0;
        clr_err  = 1'b0;
        repeat (4) tick();

        // Reset state
        check("rst_rts", rts, 1);
        check("rst_level", level, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        resetn = 1'b1;
        tick();
        check("rts_after_rst", rts, 0);
        repeat (20) tick();
        check("idle_valid", rd_valid, 0);
        check("idle_ferr", frame_err, 0);
        check("idle_ovr", overrun, 0);

        // Single byte, then a one-cycle pop
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_valid", rd_valid, 1);
        check("a5_data", rd_data, 8'hA5);
        check("a5_level", level, 1);
        drain(1);
        check("a5_level_after_pop", level, 0);

        // Back-to-back frames with no idle time
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, 1'b0);
        check("b2b_level1", level, 1);
        check("b2b_rts1", rts, 0);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 1'b0);
        check("b2b_level2", level, 2);
        check("b2b_rts2", rts, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("b2b_level3", level, 3);
        check("b2b_rts3", rts, 1);
        check("b2b_ferr", frame_err, 0);
        check("b2b_ovr", overrun, 0);
        drain(4);
        check("b2b_drained", level, 0);
        check("b2b_rts_drained", rts, 0);

        // Overrun: fifth byte dropped
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
        end
        check("full_level", level, 4);
        check("full_rts", rts, 1);
        check("full_ovr_before", overrun, 0);
        send_frame(8'h05, 1'b1, 1'b0);
        check("ovr_set", overrun, 1);
        check("ovr_level", level, 4);
        drain(6);
        check("ovr_drained", level, 0);
        pulse_clr();
        check("ovr_cleared", overrun, 0);

        // Full FIFO with a pop on the push cycle: nothing dropped
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        send_frame(8'h05, 1'b1, 1'b1);
        check("pushpop_ovr", overrun, 0);
        check("pushpop_level", level, 4);
        drain(6);
        check("pushpop_drained", level, 0);

        // Framing error followed by a break and a good frame
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40 - CLK_DIV) tick();
        rx = 1'b1;
        repeat (20) tick();
        check("ferr_set", frame_err, 1);
        check("ferr_no_push", level, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        check("ferr_next_level", level, 1);
        check("ferr_sticky", frame_err, 1);
        drain(2);
        pulse_clr();
        check("ferr_cleared", frame_err, 0);

        // Short low glitch on an idle line
        rx = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
        repeat (40) tick();
        check("glitch_level", level, 0);
        check("glitch_ferr", frame_err, 0);

        // Reset in the middle of data bit 3
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b0;
        repeat (8) tick();
        resetn = 1'b0;
        rx     = 1'b1;
        repeat (3) tick();
        check("midrst_rts", rts, 1);
        resetn = 1'b1;
        repeat (30) tick();
        check("midrst_level", level, 0);
        check("midrst_valid", rd_valid, 0);
        check("midrst_ferr", frame_err, 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0);
        check("midrst_7e_level", level, 1);
        check("midrst_7e_data", rd_data, 8'h7E);
        drain(2);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fc.md
# uart_rx_fc

Flow-controlled UART receiver: the receive end of the serial link that the SoC wrapper drives via its `tx`/`rts` pins. It recovers 8N1 frames from an asynchronous `rx` line, buffers the bytes in a small FIFO drained through a valid/ready port, and drives `rts` to throttle the remote transmitter as the FIFO fills. It is used in the host-side test harness and as the receive datapath of the on-chip UART.

## Interface
- `CLK_DIV`, 104: clk cycles per bit. Must be ≥ 8.
- `FIFO_ADDR_BITS`, 4: FIFO depth = 2^FIFO_ADDR_BITS entries.
- `RTS_MARGIN`, 4: free entries left when `rts` deasserts. Must be ≥ 1 and < depth.

- `clk` in 1: single clock; all logic is on its rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `rx` in 1: asynchronous serial input; idles high.
- `rts` out 1: active-low ready-to-send. 0 = may transmit, 1 = stop.
- `rd_data` out 8: byte at the FIFO head.
- `rd_valid` out 1: FIFO not empty.
- `rd_ready` in 1: pops the head when `rd_valid & rd_ready`.
- `level` out FIFO_ADDR_BITS+1: current FIFO occupancy.
- `frame_err` out 1: sticky; a stop bit was sampled low.
- `overrun` out 1: sticky; a good byte was dropped because the FIFO was full.
- `clr_err` in 1: one-cycle pulse that clears both sticky flags.

## Operation
- `rx` passes through a two-flop synchronizer (`rx_s`); both flops reset to 1.
- The frame FSM has states IDLE, START, DATA, STOP and BREAK. A bit counter `cnt` runs over 0..CLK_DIV-1, and a bit index `idx` runs over 0..7.
- IDLE: when `rx_s`==0, go to START with `cnt`=0.
- START: at `cnt`==CLK_DIV/2 (integer division), sample `rx_s`:
  - sample 1: glitch; return to IDLE, nothing recorded.
  - sample 0: go to DATA with `cnt`=0 and `idx`=0.
- DATA: at each `cnt`==CLK_DIV-1, sample `rx_s` into shift-register bit `idx` (LSB first) and reset `cnt`. After `idx`==7, go to STOP.
- STOP: at `cnt`==CLK_DIV-1, sample `rx_s`:
  - sample 1: push the byte and go to IDLE. This is mid-stop-bit, so back-to-back frames are not missed.
  - sample 0: set `frame_err`, discard the byte, go to BREAK.
- BREAK: wait for `rx_s`==1, then go to IDLE.
- Push when the FIFO is full:
  - If a pop happens in the same cycle, the push is accepted and `level` is unchanged.
  - Otherwise the byte is dropped and `overrun` is set.
- Pop: `rd_data` shows the head combinationally from FIFO storage. A pop on an empty FIFO has no effect.
- `level` is +1 on a push only, −1 on a pop only, unchanged on both. Read and write pointers are FIFO_ADDR_BITS wide and wrap modulo the depth.
- `rts` is registered: next value = (`level_next` ≥ 2^FIFO_ADDR_BITS − RTS_MARGIN).
- Sticky flags:
  - Both flags are 0 after reset.
  - `clr_err` clears both.
  - If a new error event occurs in the same cycle as `clr_err`, the flag ends up set (set wins).
- Frame reception continues regardless of `rts`; `rts` only advises the remote side.

## Timing
- Reset values while `resetn`=0 on an edge:
  - FSM in IDLE, `cnt`=0, `idx`=0.
  - FIFO empty, `level`=0, `rd_valid`=0.
  - `rd_data` is undefined; the bench must not check it.
  - `rts`=1, `frame_err`=0, `overrun`=0.
- After reset: `rts` falls to 0 on the first clock edge with `resetn`=1.
- Reset during a frame aborts it and discards the partial byte. The receiver rearms on the next falling edge seen after reset.
- Start detection: IDLE sees `rx_s`==0 two edges after `rx` falls; START is entered on the third edge.
- Byte latency: the push occurs on the STOP sample edge. `rd_valid` and `level` update on that same edge, so they are visible in the following cycle.
- `rts` tracks `level` with no extra delay: both update on the same edge.
- Read port: zero-latency, first-word-fall-through.

## Test plan
Bench parameters for all tests: CLK_DIV=16, FIFO_ADDR_BITS=2 (depth 4), RTS_MARGIN=1.
- Reset then idle line → `rts` reads 1 during reset and 0 from the first cycle after reset; `rd_valid`=0 and both error flags stay 0.
- Send 0xA5, `rd_ready`=0 → `rd_valid`=1 with `rd_data`=0xA5 and `level`=1; a 1-cycle pop returns `level` to 0.
- Send 0x00, 0xFF, 0x3C back-to-back with zero idle time, `rd_ready`=0 → bytes read out in order; `rts`=1 once `level`=3; no errors.
- Send 5 bytes 0x01..0x05 with no pops:
  - FIFO holds 0x01..0x04 and `overrun`=1.
  - Repeat with a pop asserted in the same cycle as the 5th push: no overrun, and 0x02..0x05 are retained.
- Frame 0x55 with the stop bit forced low, `rx` held low for 40 cycles, then high, then 0x81 sent → `frame_err`=1, no push for the bad frame, 0x81 received. `clr_err` pulse → `frame_err`=0.
- `rx` low pulse of 5 cycles (< CLK_DIV/2) → no push and no error. Also pull `resetn` low during DATA bit 3 of a frame → after reset the FIFO is empty and the next clean frame 0x7E is received correctly.
